// File: rtl/onecount_pkg.sv
// Shared definitions for the one-counter job feeder: datapath width,
// default timing constants and the sequencer state encoding.
package onecount_pkg;

   localparam int DATA_W        = 32;
   localparam int START_CYC_DEF = 4;
   localparam int TIMEOUT_DEF   = 256;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_ERR     = 3'd4,
      ST_OUT     = 3'd5
   } state_t;

endpackage

// File: rtl/onecount_feed_fifo.sv
// Small synchronous FIFO buffering words awaiting a counter job.
// Head word is visible on o_head while non-empty (first-word fall-through).
// Pushes into a full FIFO and pops from an empty one are ignored.
module onecount_feed_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_head,
   output logic              o_full,
   output logic              o_empty,
   output logic [AW:0]       o_count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   assign o_full  = (o_count == (AW+1)'(DEPTH));
   assign o_empty = (o_count == '0);
   assign push_ok = i_push & ~o_full;
   assign pop_ok  = i_pop & ~o_empty;
   assign o_head  = mem[rd_ptr];

   // Storage array: written on accepted pushes, no reset needed for data.
   always_ff @(posedge i_clk) begin
      if (push_ok) mem[wr_ptr] <= i_push_data;
   end

   // Pointers wrap naturally; the extra count bit distinguishes full from empty.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_count <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   o_count <= o_count + 1'b1;
            2'b01:   o_count <= o_count - 1'b1;
            default: o_count <= o_count;
         endcase
      end
   end

endmodule

// File: rtl/onecount_feeder.sv
// Job sequencer in front of the 32-bit one-counter FSM. Buffers incoming
// words, runs one start/done job per word (start held long enough for the
// counter's divided state clock), and returns each count on a valid/ready
// result port. A watchdog aborts jobs whose done never arrives.
// Optional: define ONECOUNT_FEEDER_ACCUM_EN to add i_total_clr / o_total,
// a running sum of successful results.
module onecount_feeder
   import onecount_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int START_CYC = START_CYC_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_in_valid,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_in_ready,
   output logic              o_cnt_start,
   output logic [DATA_W-1:0] o_cnt_data,
   input  logic              i_cnt_done,
   input  logic [DATA_W-1:0] i_cnt_data,
   output logic              o_out_valid,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_out_err,
   input  logic              i_out_ready,
   output logic              o_busy
`ifdef ONECOUNT_FEEDER_ACCUM_EN
   ,
   input  logic              i_total_clr,
   output logic [DATA_W-1:0] o_total
`endif
);

   localparam int AW  = $clog2(DEPTH);
   localparam int SCW = $clog2(START_CYC);
   localparam int WDW = $clog2(TIMEOUT + 1);

   state_t            state;
   state_t            state_n;
   logic [SCW-1:0]    sc;
   logic [WDW-1:0]    wd;
   logic              done_q;
   logic              fifo_pop;
   logic [DATA_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [AW:0]       fifo_count;

   onecount_feed_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (i_in_valid),
      .i_push_data (i_in_data),
      .i_pop       (fifo_pop),
      .o_head      (fifo_head),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty),
      .o_count     (fifo_count)
   );

   assign o_in_ready  = ~fifo_full;
   assign o_cnt_start = (state == ST_START);
   assign o_out_valid = (state == ST_OUT);
   assign o_busy      = (state != ST_IDLE) || (fifo_count != '0);

   // Next-state logic; done must be seen on two consecutive WAIT cycles,
   // and a genuine done wins over a same-cycle watchdog expiry.
   always_comb begin
      state_n  = state;
      fifo_pop = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_n  = ST_START;
            end
         end
         ST_START:   if (sc == SCW'(START_CYC - 1)) state_n = ST_WAIT;
         ST_WAIT: begin
            if (i_cnt_done && done_q)          state_n = ST_CAPTURE;
            else if (wd == WDW'(TIMEOUT - 1))  state_n = ST_ERR;
         end
         ST_CAPTURE: state_n = ST_OUT;
         ST_ERR:     state_n = ST_OUT;
         ST_OUT:     if (i_out_ready) state_n = ST_IDLE;
         default:    state_n = ST_IDLE;
      endcase
   end

   // State register plus job data, start timer, watchdog and result capture.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         sc         <= '0;
         wd         <= '0;
         done_q     <= 1'b0;
         o_cnt_data <= '0;
         o_out_data <= '0;
         o_out_err  <= 1'b0;
      end else begin
         state  <= state_n;
         done_q <= (state == ST_WAIT) && i_cnt_done;
         case (state)
            ST_IDLE: begin
               sc <= '0;
               if (!fifo_empty) o_cnt_data <= fifo_head;
            end
            ST_START: begin
               sc <= sc + 1'b1;
               wd <= '0;
            end
            ST_WAIT: wd <= wd + 1'b1;
            ST_CAPTURE: begin
               o_out_data <= i_cnt_data;
               o_out_err  <= 1'b0;
            end
            ST_ERR: begin
               o_out_data <= '0;
               o_out_err  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef ONECOUNT_FEEDER_ACCUM_EN
   // Running total of successful results; clear beats a same-cycle add.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_total <= '0;
      end else if (i_total_clr) begin
         o_total <= '0;
      end else if (o_out_valid && i_out_ready && !o_out_err) begin
         o_total <= o_total + o_out_data;
      end
   end
`endif

endmodule

// File: tb/tb_onecount_feeder.sv
// Directed self-checking bench for onecount_feeder with a behavioural
// model of the one-counter (start/done handshake).
module tb_onecount_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        cnt_start;
   logic [31:0] cnt_data;
   logic        cnt_done;
   logic [31:0] cnt_res;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_err;
   logic        out_ready;
   logic        busy;
`ifdef ONECOUNT_FEEDER_ACCUM_EN
   logic        total_clr;
   logic [31:0] total;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Counter model controls: 0 = done after mdl_lat cycles, 1 = never done,
   // 2 = one-cycle done glitch early, real done much later.
   int mdl_mode = 0;
   int mdl_lat  = 2;
   int wcnt;
   logic act;

   always #5 clk = ~clk;

   onecount_feeder dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (in_valid),
      .i_in_data   (in_data),
      .o_in_ready  (in_ready),
      .o_cnt_start (cnt_start),
      .o_cnt_data  (cnt_data),
      .i_cnt_done  (cnt_done),
      .i_cnt_data  (cnt_res),
      .o_out_valid (out_valid),
      .o_out_data  (out_data),
      .o_out_err   (out_err),
      .i_out_ready (out_ready),
      .o_busy      (busy)
`ifdef ONECOUNT_FEEDER_ACCUM_EN
      ,
      .i_total_clr (total_clr),
      .o_total     (total)
`endif
   );

   // Behavioural counter: latches the word during start, holds done/result
   // until the next start.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         act      <= 1'b0;
         wcnt     <= 0;
         cnt_done <= 1'b0;
         cnt_res  <= '0;
      end else if (cnt_start) begin
         act      <= 1'b1;
         wcnt     <= 0;
         cnt_done <= 1'b0;
         cnt_res  <= 32'($countones(cnt_data));
      end else if (act) begin
         wcnt     <= wcnt + 1;
         cnt_done <= (mdl_mode == 0 && wcnt >= mdl_lat) ||
                     (mdl_mode == 2 && (wcnt == 3 || wcnt >= 12));
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   // Present a word at a negedge and hold it until accepted.
   task automatic push_word(input logic [31:0] d);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      n = 0;
      while (!in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_accept: word %h never accepted", d);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for the start pulse to rise and then fall.
   task automatic wait_start_fall(output logic ok);
      int n;
      n = 0;
      while (!cnt_start && n < 200) begin @(negedge clk); n++; end
      while (cnt_start && n < 200)  begin @(negedge clk); n++; end
      ok = (n < 200);
   endtask

   // Run one word through with out_ready high; return the result.
   task automatic do_job(input logic [31:0] w, output logic [31:0] d,
                         output logic e, output logic ok);
      int n;
      out_ready = 1'b1;
      push_word(w);
      n = 0;
      while (!out_valid && n < 1000) begin @(negedge clk); n++; end
      ok = out_valid;
      d  = out_data;
      e  = out_err;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({in_ready, cnt_start, out_valid, out_err, busy} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 10000",
                  {in_ready, cnt_start, out_valid, out_err, busy});
      end
      n_checks++;
      if ({cnt_data, out_data} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 0", {cnt_data, out_data});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({in_ready, busy, out_valid} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_idle: got %b want 100", {in_ready, busy, out_valid});
      end
   endtask

   task automatic test_single;
      int hi, hs;
      logic bad;
      logic [31:0] d;
      logic e;
      hi = 0; hs = 0; bad = 1'b0; d = '0; e = 1'b0;
      mdl_mode = 0; mdl_lat = 2; out_ready = 1'b1;
      push_word(32'hFFFF_FFFF);
      for (int c = 0; c < 60; c++) begin
         if (cnt_start) begin
            hi++;
            if (cnt_data !== 32'hFFFF_FFFF) bad = 1'b1;
         end
         if (out_valid && out_ready) begin
            hs++;
            d = out_data;
            e = out_err;
         end
         @(negedge clk);
      end
      n_checks++;
      if (hi !== 4) begin n_fail++; $display("FAIL start_width: got %0d want 4", hi); end
      n_checks++;
      if (bad !== 1'b0) begin n_fail++; $display("FAIL start_data: got unstable want %h", 32'hFFFF_FFFF); end
      n_checks++;
      if (hs !== 1) begin n_fail++; $display("FAIL single_handshakes: got %0d want 1", hs); end
      n_checks++;
      if ({e, d} !== {1'b0, 32'd32}) begin
         n_fail++;
         $display("FAIL single_result: got err=%b data=%0d want err=0 data=32", e, d);
      end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy got %b want 0", busy); end
   endtask

   task automatic test_fill;
      logic [31:0] words [5];
      logic [31:0] expv  [5];
      logic [31:0] res   [5];
      logic        errs  [5];
      int k, n;
      words[0] = 32'h0000_0000; expv[0] = 32'd0;
      words[1] = 32'h0000_0001; expv[1] = 32'd1;
      words[2] = 32'h8000_0001; expv[2] = 32'd2;
      words[3] = 32'hF0F0_F0F0; expv[3] = 32'd16;
      words[4] = 32'hAAAA_AAAA; expv[4] = 32'd16;
      mdl_mode = 0; mdl_lat = 2; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(words[i]);
      n_checks++;
      if ({in_ready, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL fill_full: ready,busy got %b want 01", {in_ready, busy});
      end
      n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      n_checks++;
      if ({out_valid, out_err, out_data} !== {2'b10, 32'd0}) begin
         n_fail++;
         $display("FAIL fill_hold: got v=%b e=%b d=%0d want v=1 e=0 d=0",
                  out_valid, out_err, out_data);
      end
      out_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 500 && k < 5; c++) begin
         if (out_valid) begin
            res[k]  = out_data;
            errs[k] = out_err;
            k++;
         end
         @(negedge clk);
      end
      n_checks++;
      if (k !== 5) begin n_fail++; $display("FAIL fill_count: got %0d results want 5", k); end
      for (int i = 0; i < 5; i++) begin
         if (i < k) begin
            n_checks++;
            if ({errs[i], res[i]} !== {1'b0, expv[i]}) begin
               n_fail++;
               $display("FAIL fill_result%0d: got err=%b data=%0d want err=0 data=%0d",
                        i, errs[i], res[i], expv[i]);
            end
         end
      end
      n_checks++;
      if ({in_ready, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL fill_drain: ready,busy got %b want 10", {in_ready, busy});
      end
   endtask

   task automatic test_timeout;
      int c;
      logic ok;
      mdl_mode = 1; out_ready = 1'b0;
      push_word(32'h0000_0007);
      push_word(32'h0000_0003);
      wait_start_fall(ok);
      c = 0;
      while (!out_valid && c < 1000) begin @(negedge clk); c++; end
      n_checks++;
      if (c !== 257 || !ok) begin
         n_fail++;
         $display("FAIL timeout_latency: got %0d cycles want 257", c);
      end
      n_checks++;
      if ({out_valid, out_err, out_data} !== {2'b11, 32'd0}) begin
         n_fail++;
         $display("FAIL timeout_result: got v=%b e=%b d=%0d want v=1 e=1 d=0",
                  out_valid, out_err, out_data);
      end
      mdl_mode = 0;
      out_ready = 1'b1;
      @(negedge clk);
      c = 0;
      while (!out_valid && c < 1000) begin @(negedge clk); c++; end
      n_checks++;
      if ({out_valid, out_err, out_data} !== {2'b10, 32'd2}) begin
         n_fail++;
         $display("FAIL timeout_next: got v=%b e=%b d=%0d want v=1 e=0 d=2",
                  out_valid, out_err, out_data);
      end
      @(negedge clk);
   endtask

   task automatic test_glitch;
      int c;
      logic ok;
      mdl_mode = 2; out_ready = 1'b1;
      push_word(32'h0000_000F);
      wait_start_fall(ok);
      c = 0;
      while (!out_valid && c < 1000) begin @(negedge clk); c++; end
      n_checks++;
      if (c !== 16 || !ok) begin
         n_fail++;
         $display("FAIL glitch_latency: got %0d cycles want 16", c);
      end
      n_checks++;
      if ({out_err, out_data} !== {1'b0, 32'd4}) begin
         n_fail++;
         $display("FAIL glitch_result: got e=%b d=%0d want e=0 d=4", out_err, out_data);
      end
      @(negedge clk);
      mdl_mode = 0;
   endtask

   task automatic test_reset_mid;
      logic ok, seen, e;
      logic [31:0] d;
      mdl_mode = 1; out_ready = 1'b0;
      push_word(32'h0000_0001);
      push_word(32'h0000_0003);
      push_word(32'h0000_0007);
      wait_start_fall(ok);
      repeat (3) @(negedge clk);
      n_checks++;
      if ({ok, busy, cnt_data} !== {2'b11, 32'h1}) begin
         n_fail++;
         $display("FAIL midrst_pre: got ok=%b busy=%b data=%h want 1 1 1", ok, busy, cnt_data);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({in_ready, cnt_start, out_valid, out_err, busy} !== 5'b10000) begin
         n_fail++;
         $display("FAIL midrst_ctrl: got %b want 10000",
                  {in_ready, cnt_start, out_valid, out_err, busy});
      end
      n_checks++;
      if ({cnt_data, out_data} !== 64'h0) begin
         n_fail++;
         $display("FAIL midrst_data: got %h want 0", {cnt_data, out_data});
      end
      @(negedge clk);
      rst = 1'b0;
      mdl_mode = 0; out_ready = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid || busy) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet: got activity want none"); end
      do_job(32'h0000_0003, d, e, ok);
      n_checks++;
      if ({ok, e, d} !== {2'b10, 32'd2}) begin
         n_fail++;
         $display("FAIL midrst_after: got ok=%b e=%b d=%0d want 1 0 2", ok, e, d);
      end
   endtask

`ifdef ONECOUNT_FEEDER_ACCUM_EN
   task automatic test_accum;
      logic ok, e;
      logic [31:0] d;
      int n;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mdl_mode = 0;
      do_job(32'h0000_0007, d, e, ok);
      n_checks++;
      if (total !== 32'd3) begin n_fail++; $display("FAIL accum_first: got %0d want 3", total); end
      do_job(32'h0000_001F, d, e, ok);
      mdl_mode = 1;
      do_job(32'h0000_0001, d, e, ok);
      n_checks++;
      if ({ok, e} !== 2'b11) begin n_fail++; $display("FAIL accum_err: got ok,e=%b want 11", {ok, e}); end
      mdl_mode = 0;
      do_job(32'h0000_007F, d, e, ok);
      n_checks++;
      if (total !== 32'd15) begin n_fail++; $display("FAIL accum_total: got %0d want 15", total); end
      out_ready = 1'b0;
      push_word(32'h0000_000F);
      n = 0;
      while (!out_valid && n < 1000) begin @(negedge clk); n++; end
      total_clr = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      total_clr = 1'b0;
      n_checks++;
      if ({out_valid, total} !== {1'b0, 32'd0}) begin
         n_fail++;
         $display("FAIL accum_clr: got v=%b total=%0d want v=0 total=0", out_valid, total);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
`ifdef ONECOUNT_FEEDER_ACCUM_EN
      total_clr = 1'b0;
`endif
      @(negedge clk);
      test_reset();
      test_single();
      test_fill();
      test_timeout();
      test_glitch();
      test_reset_mid();
`ifdef ONECOUNT_FEEDER_ACCUM_EN
      test_accum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
